// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle DECODE/EXEC/MEM/WB control FSM with retired-instruction counter
// Optional BEQ opcode (111) enabled by defining BRANCH_EQ_EN.
module multicycle_control_fsm #(
    parameter int OPCODE_W = 3,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] control_opcode,
    input  logic                alu_zero,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                ALU_src,
    output logic                jumpp,
    output logic                branch,
    output logic [1:0]          alu_op,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired_count
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [2:0] MEM_LAST = 3'(MEM_WAIT);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [2:0]          wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic hi_zero, is_lw, is_sw, is_jump, is_add, is_addi, is_sub, is_beq, legal, mem_last;

    // The branch decision itself is taken by the datapath, so alu_zero is only passed through.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    assign hi_zero = ((op_q >> 3) == '0);
    assign is_lw   = hi_zero && (op_q[2:0] == 3'b001);
    assign is_sw   = hi_zero && (op_q[2:0] == 3'b010);
    assign is_jump = hi_zero && (op_q[2:0] == 3'b011);
    assign is_add  = hi_zero && (op_q[2:0] == 3'b100);
    assign is_addi = hi_zero && (op_q[2:0] == 3'b101);
    assign is_sub  = hi_zero && (op_q[2:0] == 3'b110);
`ifdef BRANCH_EQ_EN
    assign is_beq  = hi_zero && (op_q[2:0] == 3'b111);
`else
    assign is_beq  = 1'b0;
`endif
    assign legal    = is_lw | is_sw | is_jump | is_add | is_addi | is_sub | is_beq;
    assign mem_last = (state_q == S_MEM) && (wait_q == MEM_LAST);
    assign retired_d = retired_q + CNT_W'(pc_write);
    assign retired_count = retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d = S_DECODE;
                    op_d    = control_opcode;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (is_lw || is_sw)                   state_d = S_MEM;
                else if (is_add || is_sub || is_addi) state_d = S_WB;
                else                                  state_d = S_IDLE;
            end
            S_MEM: begin
                if (mem_last) state_d = is_lw ? S_WB : S_IDLE;
                else          wait_d  = wait_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE) && !reset;
        ir_write    = instr_ready && instr_valid;
        pc_write    = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        ALU_src     = 1'b0;
        jumpp       = 1'b0;
        branch      = 1'b0;
        alu_op      = 2'b00;
        illegal_op  = 1'b0;
        case (state_q)
            S_DECODE: begin
                illegal_op = !legal;
                pc_write   = !legal;
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    ALU_src = 1'b1;
                end else if (is_add || is_sub) begin
                    alu_op = 2'b10;
                end else if (is_addi) begin
                    alu_op  = 2'b11;
                    ALU_src = 1'b1;
                end else if (is_jump) begin
                    jumpp    = 1'b1;
                    alu_op   = 2'b01;
                    pc_write = 1'b1;
                end else if (is_beq) begin
                    branch   = 1'b1;
                    alu_op   = 2'b01;
                    pc_write = 1'b1;
                end
            end
            S_MEM: begin
                ALU_src   = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                pc_write  = is_sw && mem_last;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = is_lw;
                reg_dst    = is_add || is_sub;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - schedule-queue model check of two multicycle_control_fsm configurations
module tb_multicycle_control_fsm;
    typedef logic [13:0] vq_t[$];

    localparam logic [13:0] M_RDY = 14'h2000, M_IRW = 14'h1000, M_PC  = 14'h0800, M_RDST = 14'h0400;
    localparam logic [13:0] M_RW  = 14'h0200, M_MR  = 14'h0100, M_MW  = 14'h0080, M_M2R  = 14'h0040;
    localparam logic [13:0] M_SRC = 14'h0020, M_J   = 14'h0010, M_BR  = 14'h0008, M_ILL  = 14'h0001;
    localparam logic [13:0] A01   = 14'h0002, A10   = 14'h0004, A11   = 14'h0006;
`ifdef BRANCH_EQ_EN
    localparam bit BEQ = 1'b1;
`else
    localparam bit BEQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, valid, alu_zero;
    logic [3:0] opc;
    int total = 0, bad = 0;

    logic rdy_a, irw_a, pc_a, rdst_a, rw_a, mr_a, mw_a, m2r_a, src_a, j_a, br_a, ill_a;
    logic rdy_b, irw_b, pc_b, rdst_b, rw_b, mr_b, mw_b, m2r_b, src_b, j_b, br_b, ill_b;
    logic [1:0] aop_a, aop_b;
    logic [3:0] cnt_a;
    logic [15:0] cnt_b;
    logic [13:0] va, vb;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPCODE_W(4), .MEM_WAIT(2), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst), .instr_valid(valid), .instr_ready(rdy_a), .control_opcode(opc),
        .alu_zero(alu_zero), .ir_write(irw_a), .pc_write(pc_a), .reg_dst(rdst_a), .reg_write(rw_a),
        .mem_read(mr_a), .mem_write(mw_a), .mem_to_reg(m2r_a), .ALU_src(src_a), .jumpp(j_a),
        .branch(br_a), .alu_op(aop_a), .illegal_op(ill_a), .retired_count(cnt_a));

    multicycle_control_fsm #(.OPCODE_W(3), .MEM_WAIT(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst), .instr_valid(valid), .instr_ready(rdy_b), .control_opcode(opc[2:0]),
        .alu_zero(alu_zero), .ir_write(irw_b), .pc_write(pc_b), .reg_dst(rdst_b), .reg_write(rw_b),
        .mem_read(mr_b), .mem_write(mw_b), .mem_to_reg(m2r_b), .ALU_src(src_b), .jumpp(j_b),
        .branch(br_b), .alu_op(aop_b), .illegal_op(ill_b), .retired_count(cnt_b));

    assign va = {rdy_a, irw_a, pc_a, rdst_a, rw_a, mr_a, mw_a, m2r_a, src_a, j_a, br_a, aop_a, ill_a};
    assign vb = {rdy_b, irw_b, pc_b, rdst_b, rw_b, mr_b, mw_b, m2r_b, src_b, j_b, br_b, aop_b, ill_b};

    // Per-cycle output list of one instruction, starting with its DECODE cycle.
    function automatic vq_t sched(input logic [3:0] op, input int mw, input bit wide);
        vq_t r;
        int o;
        bit legal;
        o = int'(op[2:0]);
        legal = (!wide || !op[3]) && (o != 0) && (o != 7 || BEQ);
        if (!legal) begin
            r.push_back(M_ILL | M_PC);
            return r;
        end
        r.push_back(14'h0);
        case (o)
            1: begin
                r.push_back(M_SRC);
                for (int i = 0; i <= mw; i++) r.push_back(M_MR | M_SRC);
                r.push_back(M_RW | M_PC | M_M2R);
            end
            2: begin
                r.push_back(M_SRC);
                for (int i = 0; i < mw; i++) r.push_back(M_MW | M_SRC);
                r.push_back(M_MW | M_SRC | M_PC);
            end
            3: r.push_back(M_J | A01 | M_PC);
            4, 6: begin
                r.push_back(A10);
                r.push_back(M_RW | M_PC | M_RDST);
            end
            5: begin
                r.push_back(A11 | M_SRC);
                r.push_back(M_RW | M_PC);
            end
            default: r.push_back(M_BR | A01 | M_PC);
        endcase
        return r;
    endfunction

    vq_t q[2];
    int  mcnt[2] = '{0, 0};
    int  cyc_n = 0;

    always @(negedge clk) begin
        logic [13:0] exp_v, act_v;
        int act_c, exp_c;
        cyc_n++;
        for (int k = 0; k < 2; k++) begin
            exp_v = (q[k].size() != 0) ? q[k][0] : 14'h0;
            if (!rst && q[k].size() == 0) exp_v = exp_v | M_RDY | (valid ? M_IRW : 14'h0);
            act_v = (k == 0) ? va : vb;
            act_c = (k == 0) ? int'(cnt_a) : int'(cnt_b);
            exp_c = (k == 0) ? (mcnt[k] % 16) : (mcnt[k] % 65536);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL outputs dut%0d cyc=%0d got=%h exp=%h", k, cyc_n, act_v, exp_v);
            end
            total++;
            if (act_c != exp_c) begin
                bad++;
                $display("FAIL retired dut%0d cyc=%0d got=%0d exp=%0d", k, cyc_n, act_c, exp_c);
            end
            if (rst) begin
                q[k].delete();
                mcnt[k] = 0;
            end else if (q[k].size() == 0) begin
                if (valid) q[k] = sched(opc, (k == 0) ? 2 : 0, k == 0);
            end else begin
                if ((q[k][0] & M_PC) != 0) mcnt[k]++;
                void'(q[k].pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; opc = 4'd0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", rdy_a, 1);
        chk("reset_count", cnt_a, 0);
        chk("reset_pc_write", pc_a, 0);

        // LW on MEM_WAIT=2: mem_read t3..t5, writeback t6, ready t7
        for (int t = 0; t <= 7; t++) begin
            cyc;
            valid = (t == 0);
            opc = 4'd1;
            @(negedge clk);
            if (t == 0) chk("lw_ir_write", irw_a, 1);
            if (t == 2) chk("lw_t2_mem_read", mr_a, 0);
            if (t >= 3 && t <= 5) chk("lw_mem_read", mr_a, 1);
            if (t == 6) chk("lw_wb", {rw_a, m2r_a, pc_a, mr_a}, 4'b1110);
            if (t == 7) chk("lw_ready", rdy_a, 1);
        end

        // SW on MEM_WAIT=0: one MEM cycle with pc_write
        for (int t = 0; t <= 6; t++) begin
            cyc;
            valid = (t == 0);
            opc = 4'd2;
            @(negedge clk);
            if (t == 2) chk("sw_t2_mem_write", mw_b, 0);
            if (t == 3) chk("sw_t3", {mw_b, pc_b, rw_b}, 3'b110);
            if (t == 4) chk("sw_ready", rdy_b, 1);
        end

        // opcode 000 and a high-bit opcode are both illegal
        for (int n = 0; n < 2; n++) begin
            for (int t = 0; t <= 2; t++) begin
                cyc;
                valid = (t == 0);
                opc = (n == 0) ? 4'd0 : 4'd12;
                @(negedge clk);
                if (t == 1) chk("illegal_t1", {ill_a, pc_a, mr_a, mw_a, rw_a}, 5'b11000);
                if (t == 2) chk("illegal_ready", {rdy_a, ill_a}, 2'b10);
            end
        end

        // opcode 111
        for (int t = 0; t <= 3; t++) begin
            cyc;
            valid = (t == 0);
            opc = 4'd7;
            @(negedge clk);
            if (BEQ && t == 2) chk("beq_exec", {br_a, aop_a, pc_a}, 4'b1011);
            if (!BEQ && t == 1) chk("op7_illegal", {ill_a, br_a}, 2'b10);
        end

        // reset held through t3 and t4 of an LW
        for (int t = 0; t <= 5; t++) begin
            cyc;
            valid = (t == 0);
            opc = 4'd1;
            rst = (t == 3 || t == 4);
            @(negedge clk);
            if (t == 4) chk("abort_t4", {mr_a, pc_a, rdy_a, 28'(cnt_a)}, 32'd0);
            if (t == 5) chk("abort_ready", rdy_a, 1);
        end

        // ADD then SUB back to back with valid held high
        for (int t = 0; t <= 8; t++) begin
            cyc;
            valid = (t < 8);
            opc = (t < 4) ? 4'd4 : 4'd6;
            @(negedge clk);
            if (t == 2 || t == 6) chk("r_alu_op", aop_a, 2);
            if (t == 3 || t == 7) chk("r_wb", {rdst_a, rw_a, pc_a}, 3'b111);
            if (t == 4) chk("r_reaccept", irw_a, 1);
            if (t == 8) chk("r_count", cnt_a, 2);
        end

        // 16 jumps wrap the 4-bit counter back to its start value
        for (int i = 0; i < 48; i++) begin
            cyc;
            valid = 1'b1;
            opc = 4'd3;
            @(negedge clk);
            if (i % 3 == 2) chk("jump_exec", {j_a, pc_a, aop_a}, 4'b1101);
        end
        cyc;
        valid = 1'b0;
        @(negedge clk);
        chk("jump_wrap_a", cnt_a, 2);
        chk("jump_count_b", cnt_b, 18);

        for (int i = 0; i < 4000; i++) begin
            cyc;
            valid = ($urandom % 4) != 0;
            opc = 4'($urandom);
            alu_zero = 1'($urandom);
            rst = ($urandom % 150) == 0;
        end
        cyc;
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
